// File: rtl/con_ff_unit.sv
// Conditional-branch evaluation unit: samples the bus on an evaluate strobe, tests it
// against zero under a 3-bit condition code, and holds the decision until the PC logic acks.
module con_ff_unit #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter bit          LATCH_UNTIL_ACK = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  in_con_in,
  input  logic [2:0]            in_condition,
  input  logic [DATA_WIDTH-1:0] in_bus,
  input  logic                  in_branch_ack,
  input  logic                  in_count_clr,
  output logic                  out_branch,
  output logic                  out_valid,
  output logic [CNT_WIDTH-1:0]  out_eval_count,
  output logic [CNT_WIDTH-1:0]  out_taken_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state_q, state_d;
  logic   branch_q;
  logic   zero, neg, result;
  logic [CNT_WIDTH-1:0] eval_q, taken_q;

  // Condition decode; only consumed when in_con_in is high, so X here cannot reach state.
  always_comb begin
    zero   = (in_bus == '0);
    neg    = in_bus[DATA_WIDTH-1];
    result = 1'b0;
    case (in_condition)
      3'b000:  result = zero;
      3'b001:  result = ~zero;
      3'b010:  result = ~neg;
      3'b011:  result = neg;
      3'b100:  result = ~neg & ~zero;
      3'b101:  result = neg | zero;
      3'b110:  result = 1'b1;
      default: result = 1'b0;
    endcase
  end

  // A new strobe always wins over a concurrent ack.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (in_con_in) state_d = HOLD;
    end else begin
      if (!in_con_in && (!LATCH_UNTIL_ACK || in_branch_ack)) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      branch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_con_in) branch_q <= result;
    end
  end

  // Saturating statistics; a synchronous clear drops the evaluation of the same cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      eval_q  <= '0;
      taken_q <= '0;
    end else if (in_count_clr) begin
      eval_q  <= '0;
      taken_q <= '0;
    end else if (in_con_in) begin
      if (eval_q != CNT_MAX)            eval_q  <= eval_q + CNT_WIDTH'(1);
      if (result && taken_q != CNT_MAX) taken_q <= taken_q + CNT_WIDTH'(1);
    end
  end

  assign out_branch      = branch_q;
  assign out_valid       = (state_q == HOLD);
  assign out_eval_count  = eval_q;
  assign out_taken_count = taken_q;

endmodule

// File: doc/con_ff_unit.md
Name: con_ff_unit

Overview:
- Parametrised conditional-branch evaluation unit for the Mini-SRC datapath.
- On an evaluate strobe, it samples the bus and tests the value against zero under one of eight condition codes. It registers the branch decision and holds it with a valid flag until the PC-load logic acknowledges it.
- It also keeps saturating evaluation and taken-branch counters for debug and performance readout.
- It replaces the single-FF, bus-clocked condition logic with a fully synchronous, single-clock block.

Parameters:
- DATA_WIDTH, 32, width of the sampled bus; sign bit is bit DATA_WIDTH-1.
- CNT_WIDTH, 16, width of each statistics counter.
- LATCH_UNTIL_ACK, 1, 1 = decision held valid until in_branch_ack; 0 = out_valid is a one-cycle pulse.

Ports:
- clk  input  1  system clock, all state on rising edge
- clr  input  1  asynchronous active-low reset
- in_con_in  input  1  evaluate strobe (CON_in control signal), sampled on clk
- in_condition  input  3  condition code (IR C2 field, zero-extended)
- in_bus  input  DATA_WIDTH  value under test, sampled when in_con_in=1
- in_branch_ack  input  1  PC logic has consumed the decision
- in_count_clr  input  1  synchronous clear of both counters
- out_branch  output  1  registered branch decision
- out_valid  output  1  out_branch holds a fresh, unconsumed decision
- out_eval_count  output  CNT_WIDTH  number of evaluations
- out_taken_count  output  CNT_WIDTH  number of evaluations with result 1

Behaviour:
- Reset (clr=0, async, any state): out_branch=0, out_valid=0, both counters=0, FSM=IDLE. Reset mid-hold discards the pending decision.
- Condition decode. Let Z = (in_bus == 0) and N = in_bus[DATA_WIDTH-1].
  - 000 eq: Z
  - 001 ne: ~Z
  - 010 ge: ~N
  - 011 lt: N
  - 100 gt: ~N & ~Z
  - 101 le: N | Z
  - 110 always: 1
  - 111 never: 0
  - Codes 000-011 match the legacy 2-bit encoding.
- Evaluation is combinational on the current in_bus and in_condition. It is registered on the clk edge where in_con_in=1. Latency is 1 cycle: out_branch and out_valid update on the edge after the strobe cycle.
- FSM states: IDLE, HOLD.
  - IDLE, in_con_in=1: load out_branch, set out_valid=1, go to HOLD.
  - IDLE, in_con_in=0: no change. out_branch keeps its last value; in_branch_ack is ignored.
  - HOLD with LATCH_UNTIL_ACK=1:
    - in_con_in=1 (with or without ack): re-evaluate, overwrite out_branch, stay in HOLD. The new decision wins over the ack.
    - in_con_in=0, in_branch_ack=1: out_valid=0, go to IDLE.
    - Otherwise: hold.
  - HOLD with LATCH_UNTIL_ACK=0:
    - in_con_in=1: re-evaluate, stay in HOLD.
    - Otherwise: out_valid=0, go to IDLE. This gives a one-cycle valid pulse per strobe; back-to-back strobes keep valid high.
- out_branch is never cleared by ack. It holds the last decision until the next evaluation or reset.
- Counters:
  - out_eval_count increments on every in_con_in=1 edge.
  - out_taken_count increments when the evaluated result is 1.
  - Both saturate at all-ones and do not wrap.
- in_count_clr=1 sets both counters to 0 and has priority over a concurrent increment; the concurrent evaluation is not counted. It has no effect on the FSM or out_branch.
- X on in_condition or in_bus while in_con_in=0 must not affect state.

Test Plan:
- Reset then strobe with cond=000, bus=0 -> next cycle out_branch=1, out_valid=1, eval=1, taken=1. Then ack -> out_valid=0 next cycle, out_branch stays 1.
- Sweep all 8 codes over bus = 0, 5, 0x80000000 (DATA_WIDTH=32). Required results:
  - gt: 0, 1, 0
  - le: 1, 0, 1
  - lt: 0, 0, 1
  - ne: 0, 1, 1
  - always: 1 for all three
  - never: 0 for all three
- HOLD, then strobe cond=011 with bus=0xFFFFFFFF in the same cycle as ack -> out_valid stays 1, out_branch=1, FSM remains HOLD.
- LATCH_UNTIL_ACK=0: single strobe -> out_valid high exactly 1 cycle. Three consecutive strobes -> out_valid high 3 cycles, eval +3.
- CNT_WIDTH=4: 17 strobes with cond=110 -> both counters=15 (saturated). Then in_count_clr together with a strobe -> both counters=0.
- Assert clr low mid-HOLD, asynchronously between edges -> out_valid=0, out_branch=0, counters=0 immediately. Ack after release is ignored.
